// File: rtl/bist_multi_sequencer.sv
// Multi-channel BIST session sequencer: walks the enabled channels through
// INIT / RUN / CHECK, accumulating a sticky per-channel fail map and run status.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; status outputs hold the last result
//   S_INIT  | one-cycle setup for channel ch_sel, run counter cleared
//   S_RUN   | N stimulus cycles on channel ch_sel
//   S_CHECK | one cycle: sample ch_pass[ch_sel], advance or finish
module bist_multi_sequencer #(
   parameter int CNT_W  = 8,
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  n_cycles,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic [1:0]        mode,
   input  logic [NUM_CH-1:0] ch_pass,
   output logic              init,
   output logic              running,
   output logic              toggle,
   output logic              finish,
   output logic [CH_W-1:0]   ch_sel,
   output logic              busy,
   output logic              bist_end,
   output logic              pass,
   output logic              aborted,
   output logic [NUM_CH-1:0] fail_map
);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_CHECK} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [1:0]          mode_q, mode_d;
   logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
   logic                bist_end_q, bist_end_d;
   logic                pass_q, pass_d;
   logic                aborted_q, aborted_d;
   logic [NUM_CH-1:0]   fail_map_q, fail_map_d;

   logic [CH_W-1:0]     first_ch;
   logic [CH_W-1:0]     next_ch;
   logic                next_found;
   logic [NUM_CH-1:0]   fm_upd;
   logic                pattern;

   // Descending scans so the last hit is the lowest qualifying index.
   always_comb begin
      first_ch   = '0;
      next_ch    = ch_sel_q;
      next_found = 1'b0;
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (ch_enable[i]) first_ch = CH_W'(i);
      end
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(ch_sel_q))) begin
            next_found = 1'b1;
            next_ch    = CH_W'(i);
         end
      end
   end

   always_comb begin
      fm_upd = fail_map_q;
      if (!ch_pass[ch_sel_q]) fm_upd[ch_sel_q] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      mask_d     = mask_q;
      mode_d     = mode_q;
      ch_sel_d   = ch_sel_q;
      bist_end_d = bist_end_q;
      pass_d     = pass_q;
      aborted_d  = aborted_q;
      fail_map_d = fail_map_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (|ch_enable) begin
                  n_d        = (n_cycles == '0) ? CNT_W'(1) : n_cycles;
                  mask_d     = ch_enable;
                  mode_d     = mode;
                  ch_sel_d   = first_ch;
                  bist_end_d = 1'b0;
                  pass_d     = 1'b0;
                  aborted_d  = 1'b0;
                  fail_map_d = '0;
                  state_d    = S_INIT;
               end else begin
                  bist_end_d = 1'b1;
                  pass_d     = 1'b1;
                  aborted_d  = 1'b0;
                  fail_map_d = '0;
               end
            end
         end
         S_INIT: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == n_q - 1'b1) state_d = S_CHECK;
         end
         S_CHECK: begin
            fail_map_d = fm_upd;
            if (next_found) begin
               ch_sel_d = next_ch;
               state_d  = S_INIT;
            end else begin
               state_d    = S_IDLE;
               bist_end_d = 1'b1;
               pass_d     = (fm_upd == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort wins even over the final CHECK, whose sample is then discarded.
      if (abort && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         cnt_d      = cnt_q;
         ch_sel_d   = ch_sel_q;
         bist_end_d = 1'b1;
         aborted_d  = 1'b1;
         pass_d     = 1'b0;
         fail_map_d = fail_map_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         n_q        <= '0;
         mask_q     <= '0;
         mode_q     <= '0;
         ch_sel_q   <= '0;
         bist_end_q <= 1'b0;
         pass_q     <= 1'b0;
         aborted_q  <= 1'b0;
         fail_map_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         mask_q     <= mask_d;
         mode_q     <= mode_d;
         ch_sel_q   <= ch_sel_d;
         bist_end_q <= bist_end_d;
         pass_q     <= pass_d;
         aborted_q  <= aborted_d;
         fail_map_q <= fail_map_d;
      end
   end

   always_comb begin
      case (mode_q)
         2'd1:    pattern = 1'b1;
         2'd2:    pattern = 1'b0;
         default: pattern = ~cnt_q[0];
      endcase
   end

   assign init     = (state_q == S_INIT);
   assign running  = (state_q == S_RUN);
   assign finish   = (state_q == S_CHECK);
   assign toggle   = running & pattern;
   assign busy     = (state_q != S_IDLE);
   assign ch_sel   = ch_sel_q;
   assign bist_end = bist_end_q;
   assign pass     = pass_q;
   assign aborted  = aborted_q;
   assign fail_map = fail_map_q;

endmodule
